sim_test_device: RTL

//  Memory-mapped simulation controller on the CPU data-memory port, alongside data_memory in the sim top.

---
 rtl/sim_dev_pkg.sv | 26 ++
 rtl/sim_test_device_fifo.sv | 69 ++++++
 rtl/sim_test_device.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/sim_dev_pkg.sv
// Shared definitions for the simulation controller: register offsets,
// termination state encoding and the tohost pass code.
package sim_dev_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PASS    = 2'd1,
        ST_FAIL    = 2'd2,
        ST_TIMEOUT = 2'd3
    } sim_state_e;

    // Word offsets within the 32-byte window (addr[4:2])
    localparam logic [2:0] OFF_TOHOST  = 3'd0;
    localparam logic [2:0] OFF_CONSOLE = 3'd1;
    localparam logic [2:0] OFF_CYC_LO  = 3'd2;
    localparam logic [2:0] OFF_CYC_HI  = 3'd3;
    localparam logic [2:0] OFF_STATUS  = 3'd4;

    localparam logic [31:0] PASS_CODE = 32'd1;

    // Odd tohost values other than the pass code report a failure
    function automatic logic is_fail_code(input logic [31:0] v);
        return v[0] && (v != PASS_CODE);
    endfunction

endpackage

// File: rtl/sim_test_device_fifo.sv
// Circular buffer with occupancy count; head word is visible without a pop
// and a push into a full buffer is only accepted when a pop frees a slot.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             overflow
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             overflow_r;
    logic             full_s;
    logic             pop_s;
    logic             push_ok_s;

    assign full_s    = (count_r == CW'(DEPTH));
    assign valid     = (count_r != {CW{1'b0}});
    assign pop_s     = valid & ready;
    assign push_ok_s = push & (~full_s | pop_s);
    assign dout      = valid ? mem_r[rd_ptr_r] : {WIDTH{1'b0}};
    assign count     = count_r;
    assign overflow  = overflow_r;

    // Storage array; content is don't-care until pushed
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
            if (push && full_s && !pop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sim_test_device.sv
// Memory-mapped simulation controller: tohost pass/fail, cycle counter with
// watchdog, and a console byte FIFO drained by the testbench.
module sim_test_device
    import sim_dev_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h0001_0000,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned CON_DEPTH      = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        rd_en,
    input  logic        wr_en,
    output logic        hit,
    output logic [31:0] rdata,
    output logic        con_valid,
    output logic [7:0]  con_data,
    input  logic        con_ready,
    output logic        done,
    output logic        pass,
    output logic [30:0] fail_code,
    output logic        timeout
);

    localparam int unsigned CW      = $clog2(CON_DEPTH) + 1;
    localparam bit          WD_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [63:0] WD_LAST = WD_EN ? (64'(TIMEOUT_CYCLES) - 64'd1) : 64'd0;
    localparam logic [7:0]  DEPTH8  = 8'(CON_DEPTH);

    sim_state_e    state_r;
    sim_state_e    state_n;
    logic [63:0]   cycle_r;
    logic [31:0]   tohost_r;
    logic [30:0]   fail_code_r;
    logic [30:0]   fail_code_n;
    logic          done_r;
    logic          pass_r;
    logic          timeout_r;
    logic [2:0]    off_s;
    logic          wr_hit_s;
    logic          tohost_wr_s;
    logic          con_push_s;
    logic          wd_fire_s;
    logic [CW-1:0] con_count_s;
    logic          overflow_s;
    logic [7:0]    free_s;
    logic [31:0]   rdata_s;
    logic          unused_addr_s;

    // Byte lanes within a word are ignored; only word accesses are decoded
    assign unused_addr_s = ^addr[1:0];
    assign hit           = (addr[31:5] == BASE_ADDR[31:5]);
    assign off_s         = addr[4:2];
    assign wr_hit_s      = wr_en & hit;
    assign tohost_wr_s   = wr_hit_s & (off_s == OFF_TOHOST);
    assign con_push_s    = wr_hit_s & (off_s == OFF_CONSOLE);
    assign wd_fire_s     = WD_EN && (cycle_r == WD_LAST);
    assign free_s        = DEPTH8 - 8'(con_count_s);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (CON_DEPTH)
    ) u_con_fifo (
        .clk      (clk),
        .rst      (reset),
        .push     (con_push_s),
        .din      (wdata[7:0]),
        .ready    (con_ready),
        .valid    (con_valid),
        .dout     (con_data),
        .count    (con_count_s),
        .overflow (overflow_s)
    );

    // Next-state: only RUN can leave, and a tohost write beats the watchdog
    always_comb begin
        state_n     = state_r;
        fail_code_n = fail_code_r;
        case (state_r)
            ST_RUN: begin
                if (tohost_wr_s && (wdata == PASS_CODE)) begin
                    state_n = ST_PASS;
                end else if (tohost_wr_s && is_fail_code(wdata)) begin
                    state_n     = ST_FAIL;
                    fail_code_n = wdata[31:1];
                end else if (wd_fire_s) begin
                    state_n = ST_TIMEOUT;
                end else begin
                    state_n = ST_RUN;
                end
            end
            default: begin
                state_n = state_r;
            end
        endcase
    end

    // State, cycle counter, tohost shadow and registered status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_RUN;
            cycle_r     <= 64'd0;
            tohost_r    <= 32'd0;
            fail_code_r <= 31'd0;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            timeout_r   <= 1'b0;
        end else begin
            state_r     <= state_n;
            fail_code_r <= fail_code_n;
            done_r      <= (state_n != ST_RUN);
            pass_r      <= (state_n == ST_PASS);
            timeout_r   <= (state_n == ST_TIMEOUT);
            if (state_r == ST_RUN) begin
                cycle_r <= cycle_r + 64'd1;
                if (tohost_wr_s) begin
                    tohost_r <= wdata;
                end
            end
        end
    end

    // Same-cycle read mux for the single-cycle CPU
    always_comb begin
        rdata_s = 32'd0;
        if (rd_en && hit) begin
            case (off_s)
                OFF_TOHOST:  rdata_s = tohost_r;
                OFF_CONSOLE: rdata_s = {overflow_s, 23'd0, free_s};
                OFF_CYC_LO:  rdata_s = cycle_r[31:0];
                OFF_CYC_HI:  rdata_s = cycle_r[63:32];
                OFF_STATUS:  rdata_s = {29'd0, overflow_s, state_r};
                default:     rdata_s = 32'd0;
            endcase
        end else begin
            rdata_s = 32'd0;
        end
    end

    assign rdata     = rdata_s;
    assign done      = done_r;
    assign pass      = pass_r;
    assign timeout   = timeout_r;
    assign fail_code = fail_code_r;

endmodule
